// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register. Holds the PC, talks to the
// I-cache over a level-held req / single-cycle ready handshake, and absorbs misses,
// load-use stalls and redirects that arrive while a miss is outstanding.
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_retain,
  input  logic        IF_ID_retain,
  input  logic        IF_ID_flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_ready,
  input  logic [31:0] icache_rdata,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid,
  output logic        fetch_stall
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] buf_instr, buf_instr_next;
  logic [31:0] buf_pc, buf_pc_next;
  logic [31:0] saved_target, saved_target_next;

  logic        deliver;
  logic [31:0] deliver_pc;
  logic [31:0] deliver_instr;

  logic [31:0] id_pc_next;
  logic [31:0] id_instr_next;
  logic        id_valid_next;

  logic [31:0] target_aligned;
  logic [31:0] pc_plus4;
  logic [31:0] drain_target;

  // Redirect targets are always word aligned; the low two bits carry no information.
  assign target_aligned = {branch_target[31:2], 2'b00};
  assign pc_plus4       = pc + 32'd4;

  logic unused_target_bits;
  assign unused_target_bits = ^branch_target[1:0];

  // The cache cannot abort a request, so the address is simply the PC, which is
  // never changed while a request is in flight.
  assign icache_req  = !rst && (state != HOLD);
  assign icache_addr = pc;
  assign fetch_stall = icache_req && ((state == DRAIN) || !icache_ready);

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_next        = state;
    pc_next           = pc;
    buf_instr_next    = buf_instr;
    buf_pc_next       = buf_pc;
    saved_target_next = saved_target;
    deliver           = 1'b0;
    deliver_pc        = pc;
    deliver_instr     = icache_rdata;
    drain_target      = branch_taken ? target_aligned : saved_target;

    unique case (state)
      FETCH: begin
        if (icache_ready) begin
          if (branch_taken) begin
            pc_next = target_aligned;
          end else if (PC_retain) begin
            buf_instr_next = icache_rdata;
            buf_pc_next    = pc;
            state_next     = HOLD;
          end else begin
            deliver = 1'b1;
            pc_next = pc_plus4;
          end
        end else if (branch_taken) begin
          saved_target_next = target_aligned;
          state_next        = DRAIN;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_next    = target_aligned;
          state_next = FETCH;
        end else if (!PC_retain) begin
          deliver       = 1'b1;
          deliver_pc    = buf_pc;
          deliver_instr = buf_instr;
          pc_next       = pc_plus4;
          state_next    = FETCH;
        end
      end

      DRAIN: begin
        // The latest redirect wins, even in the cycle the stale word returns.
        saved_target_next = drain_target;
        if (icache_ready) begin
          pc_next    = drain_target;
          state_next = FETCH;
        end
      end

      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    id_pc_next    = IF_ID_pc;
    id_instr_next = IF_ID_instr;
    id_valid_next = IF_ID_valid;
    if (IF_ID_flush) begin
      id_pc_next    = 32'h0000_0000;
      id_instr_next = NOP_INSTR;
      id_valid_next = 1'b0;
    end else if (IF_ID_retain) begin
      id_pc_next    = IF_ID_pc;
    end else if (deliver) begin
      id_pc_next    = deliver_pc;
      id_instr_next = deliver_instr;
      id_valid_next = 1'b1;
    end else begin
      id_instr_next = NOP_INSTR;
      id_valid_next = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= PC_RESET;
      buf_instr    <= NOP_INSTR;
      buf_pc       <= 32'h0000_0000;
      saved_target <= 32'h0000_0000;
      IF_ID_pc     <= 32'h0000_0000;
      IF_ID_instr  <= NOP_INSTR;
      IF_ID_valid  <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      buf_instr    <= buf_instr_next;
      buf_pc       <= buf_pc_next;
      saved_target <= saved_target_next;
      IF_ID_pc     <= id_pc_next;
      IF_ID_instr  <= id_instr_next;
      IF_ID_valid  <= id_valid_next;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus a randomized run
// compared against a transaction-level model of the fetch stream.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_retain, IF_ID_retain, IF_ID_flush, branch_taken;
  logic [31:0] branch_target;
  logic        icache_ready;
  logic [31:0] icache_rdata;

  logic        icache_req;
  logic [31:0] icache_addr;
  logic [31:0] IF_ID_pc, IF_ID_instr;
  logic        IF_ID_valid, fetch_stall;

  logic        w_req;
  logic [31:0] w_addr, w_pc, w_instr;
  logic        w_valid, w_stall;

  int n_pass  = 0;
  int n_total = 0;

  if_fetch_stage dut (
    .clk(clk), .rst(rst),
    .PC_retain(PC_retain), .IF_ID_retain(IF_ID_retain), .IF_ID_flush(IF_ID_flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_ready(icache_ready), .icache_rdata(icache_rdata),
    .IF_ID_pc(IF_ID_pc), .IF_ID_instr(IF_ID_instr), .IF_ID_valid(IF_ID_valid),
    .fetch_stall(fetch_stall)
  );

  if_fetch_stage #(.PC_RESET(32'hFFFF_FFFC)) wdut (
    .clk(clk), .rst(rst),
    .PC_retain(PC_retain), .IF_ID_retain(IF_ID_retain), .IF_ID_flush(IF_ID_flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .icache_req(w_req), .icache_addr(w_addr),
    .icache_ready(icache_ready), .icache_rdata(icache_rdata),
    .IF_ID_pc(w_pc), .IF_ID_instr(w_instr), .IF_ID_valid(w_valid),
    .fetch_stall(w_stall)
  );

  always #5 clk = ~clk;

  // Instruction memory contents seen by the cache model.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic clear_inputs();
    PC_retain     = 1'b0;
    IF_ID_retain  = 1'b0;
    IF_ID_flush   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    icache_ready  = 1'b0;
    icache_rdata  = 32'h0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_hits(input int n);
    for (int i = 0; i < n; i++) begin
      icache_ready = 1'b1;
      icache_rdata = mem(icache_addr);
      @(posedge clk);
      #1;
    end
    icache_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    n_total++;
    if (icache_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", icache_req);
    else n_pass++;
    n_total++;
    if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {1'b0, 32'h0, 32'h0})
      $display("FAIL reset_ifid: got %b/%h/%h expected 0/0/0", IF_ID_valid, IF_ID_pc, IF_ID_instr);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_total++;
    if ({icache_req, icache_addr} !== {1'b1, 32'h0})
      $display("FAIL reset_first_req: got %b/%h expected 1/00000000", icache_req, icache_addr);
    else n_pass++;
    n_total++;
    if (fetch_stall !== 1'b1) $display("FAIL reset_stall: got %b expected 1", fetch_stall);
    else n_pass++;
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = 32'(4 * i);
      icache_ready = 1'b1;
      icache_rdata = mem(a);
      #1;
      n_total++;
      if ({icache_req, icache_addr, fetch_stall} !== {1'b1, a, 1'b0})
        $display("FAIL stream_addr[%0d]: got %b/%h/%b expected 1/%h/0", i, icache_req, icache_addr, fetch_stall, a);
      else n_pass++;
      n_total++;
      if (i == 0) begin
        if (IF_ID_valid !== 1'b0) $display("FAIL stream_first_valid: got %b expected 0", IF_ID_valid);
        else n_pass++;
      end else if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {1'b1, a - 32'd4, mem(a - 32'd4)}) begin
        $display("FAIL stream_ifid[%0d]: got %b/%h/%h expected 1/%h/%h", i, IF_ID_valid, IF_ID_pc,
                 IF_ID_instr, a - 32'd4, mem(a - 32'd4));
      end else n_pass++;
      @(posedge clk);
      #1;
    end
    icache_ready = 1'b0;
  endtask

  task automatic test_miss();
    apply_reset();
    run_hits(4);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++;
      if ({fetch_stall, icache_addr} !== {1'b1, 32'h10})
        $display("FAIL miss_stall[%0d]: got %b/%h expected 1/00000010", k, fetch_stall, icache_addr);
      else n_pass++;
      if (k > 0) begin
        n_total++;
        if ({IF_ID_valid, IF_ID_instr} !== {1'b0, 32'h0})
          $display("FAIL miss_bubble[%0d]: got %b/%h expected 0/00000000", k, IF_ID_valid, IF_ID_instr);
        else n_pass++;
      end
      @(posedge clk);
      #1;
    end
    icache_ready = 1'b1;
    icache_rdata = 32'h8C22_0004;
    #1;
    n_total++;
    if (fetch_stall !== 1'b0) $display("FAIL miss_ready_stall: got %b expected 0", fetch_stall);
    else n_pass++;
    @(posedge clk);
    #1;
    icache_ready = 1'b0;
    n_total++;
    if ({IF_ID_valid, IF_ID_pc, IF_ID_instr, icache_addr} !== {1'b1, 32'h10, 32'h8C22_0004, 32'h14})
      $display("FAIL miss_deliver: got %b/%h/%h addr %h expected 1/00000010/8c220004 addr 00000014",
               IF_ID_valid, IF_ID_pc, IF_ID_instr, icache_addr);
    else n_pass++;
  endtask

  task automatic test_load_use();
    apply_reset();
    run_hits(8);
    icache_ready = 1'b1;
    icache_rdata = 32'h0043_1020;
    PC_retain    = 1'b1;
    IF_ID_retain = 1'b1;
    @(posedge clk);
    #1;
    icache_ready = 1'b0;
    n_total++;
    if ({icache_req, fetch_stall} !== 2'b00)
      $display("FAIL loaduse_hold_req: got %b/%b expected 0/0", icache_req, fetch_stall);
    else n_pass++;
    n_total++;
    if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {1'b1, 32'h1C, mem(32'h1C)})
      $display("FAIL loaduse_ifid_held: got %b/%h/%h expected 1/0000001c/%h", IF_ID_valid, IF_ID_pc,
               IF_ID_instr, mem(32'h1C));
    else n_pass++;
    PC_retain    = 1'b0;
    IF_ID_retain = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {1'b1, 32'h20, 32'h0043_1020})
      $display("FAIL loaduse_deliver: got %b/%h/%h expected 1/00000020/00431020", IF_ID_valid, IF_ID_pc, IF_ID_instr);
    else n_pass++;
    n_total++;
    if ({icache_req, icache_addr} !== {1'b1, 32'h24})
      $display("FAIL loaduse_next_addr: got %b/%h expected 1/00000024", icache_req, icache_addr);
    else n_pass++;
  endtask

  task automatic test_redirect_miss();
    apply_reset();
    run_hits(16);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    for (int k = 0; k < 2; k++) begin
      icache_ready = (k == 1);
      icache_rdata = 32'hDEAD_BEEF;
      #1;
      n_total++;
      if ({icache_req, icache_addr, fetch_stall, IF_ID_valid} !== {1'b1, 32'h40, 1'b1, 1'b0})
        $display("FAIL redirect_drain[%0d]: got %b/%h/%b/%b expected 1/00000040/1/0", k, icache_req,
                 icache_addr, fetch_stall, IF_ID_valid);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    icache_ready = 1'b0;
    n_total++;
    if ({icache_req, icache_addr, IF_ID_valid} !== {1'b1, 32'h100, 1'b0})
      $display("FAIL redirect_target: got %b/%h/%b expected 1/00000100/0", icache_req, icache_addr, IF_ID_valid);
    else n_pass++;
    icache_ready = 1'b1;
    icache_rdata = mem(32'h100);
    @(posedge clk);
    #1;
    icache_ready = 1'b0;
    n_total++;
    if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {1'b1, 32'h100, mem(32'h100)})
      $display("FAIL redirect_deliver: got %b/%h/%h expected 1/00000100/%h", IF_ID_valid, IF_ID_pc,
               IF_ID_instr, mem(32'h100));
    else n_pass++;
  endtask

  task automatic test_flush_priority();
    apply_reset();
    run_hits(3);
    icache_ready = 1'b1;
    icache_rdata = mem(32'hC);
    IF_ID_flush  = 1'b1;
    IF_ID_retain = 1'b1;
    @(posedge clk);
    #1;
    clear_inputs();
    n_total++;
    if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {1'b0, 32'h0, 32'h0})
      $display("FAIL flush_wins: got %b/%h/%h expected 0/00000000/00000000", IF_ID_valid, IF_ID_pc, IF_ID_instr);
    else n_pass++;
    n_total++;
    if (icache_addr !== 32'h10) $display("FAIL flush_pc_advance: got %h expected 00000010", icache_addr);
    else n_pass++;
  endtask

  task automatic test_wrap();
    apply_reset();
    icache_ready = 1'b1;
    icache_rdata = 32'h1234_5678;
    #1;
    n_total++;
    if ({w_req, w_addr} !== {1'b1, 32'hFFFF_FFFC})
      $display("FAIL wrap_first: got %b/%h expected 1/fffffffc", w_req, w_addr);
    else n_pass++;
    @(posedge clk);
    #1;
    icache_ready = 1'b0;
    n_total++;
    if ({w_addr, w_valid, w_pc, w_instr} !== {32'h0, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678})
      $display("FAIL wrap_second: got %h/%b/%h/%h expected 00000000/1/fffffffc/12345678", w_addr, w_valid, w_pc, w_instr);
    else n_pass++;
  endtask

  task automatic test_reset_in_drain();
    apply_reset();
    run_hits(2);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0200;
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    rst = 1'b1;
    #1;
    n_total++;
    if ({icache_req, IF_ID_valid, IF_ID_instr} !== {1'b0, 1'b0, 32'h0})
      $display("FAIL rstdrain_async: got %b/%b/%h expected 0/0/00000000", icache_req, IF_ID_valid, IF_ID_instr);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_total++;
    if ({icache_req, icache_addr} !== {1'b1, 32'h0})
      $display("FAIL rstdrain_restart: got %b/%h expected 1/00000000", icache_req, icache_addr);
    else n_pass++;
    icache_ready = 1'b1;
    icache_rdata = mem(32'h0);
    @(posedge clk);
    #1;
    icache_ready = 1'b0;
    n_total++;
    if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {1'b1, 32'h0, mem(32'h0)})
      $display("FAIL rstdrain_deliver: got %b/%h/%h expected 1/00000000/%h", IF_ID_valid, IF_ID_pc, IF_ID_instr, mem(32'h0));
    else n_pass++;
  endtask

  // Model tracks the fetch stream as: next address to fetch, an optional parked
  // word, an optional pending redirect, and the contents of IF/ID.
  task automatic test_random(input int cycles);
    logic [31:0] m_pc, m_buf, m_buf_pc, m_target, m_id_pc, m_id_instr;
    logic        m_has_buf, m_draining, m_id_valid;
    int          errs;
    apply_reset();
    m_pc = 32'h0; m_buf = 32'h0; m_buf_pc = 32'h0; m_target = 32'h0;
    m_id_pc = 32'h0; m_id_instr = 32'h0; m_id_valid = 1'b0;
    m_has_buf = 1'b0; m_draining = 1'b0;
    errs = 0;
    for (int c = 0; c < cycles; c++) begin
      logic        e_req, del;
      logic [31:0] tgt, d_pc, d_instr;
      e_req         = !m_has_buf;
      PC_retain     = ($urandom_range(0, 4) == 0);
      IF_ID_retain  = PC_retain && ($urandom_range(0, 3) != 0);
      IF_ID_flush   = ($urandom_range(0, 9) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      branch_target = $urandom;
      icache_ready  = e_req && ($urandom_range(0, 2) != 0);
      icache_rdata  = $urandom;
      #1;
      n_total++;
      if (icache_req !== e_req || (e_req && icache_addr !== m_pc)) begin
        if (errs < 10) $display("FAIL rand_req[%0d]: got %b/%h expected %b/%h", c, icache_req, icache_addr, e_req, m_pc);
        errs++;
      end else n_pass++;
      n_total++;
      if (fetch_stall !== (e_req && (m_draining || !icache_ready))) begin
        if (errs < 10) $display("FAIL rand_stall[%0d]: got %b expected %b", c, fetch_stall,
                                e_req && (m_draining || !icache_ready));
        errs++;
      end else n_pass++;
      n_total++;
      if ({IF_ID_valid, IF_ID_pc, IF_ID_instr} !== {m_id_valid, m_id_pc, m_id_instr}) begin
        if (errs < 10) $display("FAIL rand_ifid[%0d]: got %b/%h/%h expected %b/%h/%h", c, IF_ID_valid,
                                IF_ID_pc, IF_ID_instr, m_id_valid, m_id_pc, m_id_instr);
        errs++;
      end else n_pass++;

      tgt = {branch_target[31:2], 2'b00};
      del = 1'b0; d_pc = 32'h0; d_instr = 32'h0;
      if (m_has_buf) begin
        if (branch_taken) begin
          m_has_buf = 1'b0; m_pc = tgt;
        end else if (!PC_retain) begin
          del = 1'b1; d_pc = m_buf_pc; d_instr = m_buf; m_pc = m_pc + 32'd4; m_has_buf = 1'b0;
        end
      end else if (m_draining) begin
        if (branch_taken) m_target = tgt;
        if (icache_ready) begin
          m_pc = m_target; m_draining = 1'b0;
        end
      end else if (icache_ready) begin
        if (branch_taken) m_pc = tgt;
        else if (PC_retain) begin
          m_has_buf = 1'b1; m_buf = icache_rdata; m_buf_pc = m_pc;
        end else begin
          del = 1'b1; d_pc = m_pc; d_instr = icache_rdata; m_pc = m_pc + 32'd4;
        end
      end else if (branch_taken) begin
        m_draining = 1'b1; m_target = tgt;
      end
      if (IF_ID_flush) begin
        m_id_valid = 1'b0; m_id_instr = 32'h0; m_id_pc = 32'h0;
      end else if (!IF_ID_retain) begin
        if (del) begin
          m_id_valid = 1'b1; m_id_pc = d_pc; m_id_instr = d_instr;
        end else begin
          m_id_valid = 1'b0; m_id_instr = 32'h0;
        end
      end
      @(posedge clk);
      #1;
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_stream();
    test_miss();
    test_load_use();
    test_redirect_miss();
    test_flush_priority();
    test_wrap();
    test_reset_in_drain();
    test_random(3000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
